// File: rtl/beezip_job_scheduler_pkg.sv
// rtl/beezip_job_scheduler_pkg.sv - shared defaults and state encoding for the beezip job scheduler
package beezip_job_scheduler_pkg;

    // Beat width of the beezip input port is HASH_ISSUE_WIDTH bytes.
    localparam int HASH_ISSUE_WIDTH   = 4;
    localparam int SCHED_NUM_CH       = 4;
    localparam int SCHED_MAX_INFLIGHT = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_e;

endpackage

// File: rtl/beezip_job_scheduler_fifo.sv
// rtl/beezip_job_scheduler_fifo.sv - synchronous tag queue holding the owner channel of each in-flight job
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   input_valid/input_ready/input_data  push side
//   output_valid/output_ready/output_data  pop side; output_data is zero while empty
module fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [W-1:0] input_data,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [W-1:0] output_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign input_ready  = (count_q != CNT_W'(DEPTH));
    assign output_valid = (count_q != '0);
    assign output_data  = output_valid ? mem_q[rd_ptr_q] : '0;
    assign push         = input_valid && input_ready;
    assign pop          = output_valid && output_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = input_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/beezip_job_scheduler.sv
// rtl/beezip_job_scheduler.sv - round-robin job-level arbiter sharing one beezip input among NUM_CH streams
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cfg_enable                       allows new grants; current job always completes
//   ch_valid/ch_ready/ch_delim/ch_data  per-channel beat streams (channel i at [i*DATA_W +: DATA_W])
//   bz_input_valid/ready/delim/data  beat stream into beezip
//   job_done                         retire pulse for the oldest in-flight job
//   head_job_valid/head_job_ch       owner of the oldest in-flight job
//   inflight_cnt                     jobs granted but not yet retired
//   busy                             streaming or jobs in flight
//   err_done_underflow               sticky: job_done seen with nothing in flight
module beezip_job_scheduler
    import beezip_job_scheduler_pkg::*;
#(
    parameter int NUM_CH       = SCHED_NUM_CH,
    parameter int CH_W         = 2,
    parameter int MAX_INFLIGHT = SCHED_MAX_INFLIGHT,
    parameter int DATA_W       = HASH_ISSUE_WIDTH * 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_enable,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH-1:0]            ch_delim,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data,
    output logic                         bz_input_valid,
    input  logic                         bz_input_ready,
    output logic                         bz_input_delim,
    output logic [DATA_W-1:0]            bz_input_data,
    input  logic                         job_done,
    output logic                         head_job_valid,
    output logic [CH_W-1:0]              head_job_ch,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt,
    output logic                         busy,
    output logic                         err_done_underflow
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    sched_state_e     state_q, state_d;
    logic [CH_W-1:0]  grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] inflight_cnt_q, inflight_cnt_d;
    logic             err_q, err_d;

    logic [DATA_W-1:0] ch_data_arr [NUM_CH];
    logic [CH_W-1:0]   pick_ch;
    logic              tag_ready;
    logic              grant;
    logic              done_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end

    // First valid channel at or above ptr, wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] v,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] cand;
        logic            found;
        int              sum;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            cand = CH_W'(sum);
            if (!found && v[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_ch = rr_pick(ch_valid, rr_ptr_q);
    // A pop only counts when something is actually in flight.
    assign done_ok = job_done && (inflight_cnt_q != '0);

    always_comb begin
        state_d        = state_q;
        grant_ch_d     = grant_ch_q;
        rr_ptr_d       = rr_ptr_q;
        grant          = 1'b0;
        ch_ready       = '0;
        bz_input_valid = 1'b0;
        // Data/delim always follow the last granted channel; only valid/ready are gated.
        bz_input_data  = ch_data_arr[grant_ch_q];
        bz_input_delim = ch_delim[grant_ch_q];
        case (state_q)
            ST_IDLE: begin
                // Full check uses the registered count, so a same-cycle job_done
                // never makes room for a grant.
                if (cfg_enable && (inflight_cnt_q < CNT_W'(MAX_INFLIGHT)) &&
                    (ch_valid != '0) && tag_ready) begin
                    grant      = 1'b1;
                    grant_ch_d = pick_ch;
                    rr_ptr_d   = (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + CH_W'(1);
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                bz_input_valid       = ch_valid[grant_ch_q];
                ch_ready[grant_ch_q] = bz_input_ready;
                if (ch_valid[grant_ch_q] && bz_input_ready && ch_delim[grant_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_cnt_d = inflight_cnt_q + CNT_W'(grant) - CNT_W'(done_ok);
        err_d          = err_q || (job_done && (inflight_cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_ch_q     <= '0;
            rr_ptr_q       <= '0;
            inflight_cnt_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_ch_q     <= grant_ch_d;
            rr_ptr_q       <= rr_ptr_d;
            inflight_cnt_q <= inflight_cnt_d;
            err_q          <= err_d;
        end
    end

    fifo #(
        .W     (CH_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_valid  (grant),
        .input_ready  (tag_ready),
        .input_data   (grant_ch_d),
        .output_valid (head_job_valid),
        .output_ready (done_ok),
        .output_data  (head_job_ch)
    );

    assign inflight_cnt       = inflight_cnt_q;
    assign busy               = (state_q != ST_IDLE) || (inflight_cnt_q != '0);
    assign err_done_underflow = err_q;

endmodule

// File: tb/tb_beezip_job_scheduler.sv
// tb/tb_beezip_job_scheduler.sv - self-checking bench for beezip_job_scheduler
module tb_beezip_job_scheduler;
    import beezip_job_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int MAXI = 4;
    localparam int DW   = HASH_ISSUE_WIDTH * 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_enable;
    logic [N-1:0]    ch_valid;
    logic [N-1:0]    ch_ready;
    logic [N-1:0]    ch_delim;
    logic [N*DW-1:0] ch_data;
    logic            bz_input_valid;
    logic            bz_input_ready;
    logic            bz_input_delim;
    logic [DW-1:0]   bz_input_data;
    logic            job_done;
    logic            head_job_valid;
    logic [CW-1:0]   head_job_ch;
    logic [2:0]      inflight_cnt;
    logic            busy;
    logic            err_done_underflow;

    always #5 clk = ~clk;

    beezip_job_scheduler #(
        .NUM_CH       (N),
        .CH_W         (CW),
        .MAX_INFLIGHT (MAXI),
        .DATA_W       (DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_enable         (cfg_enable),
        .ch_valid           (ch_valid),
        .ch_ready           (ch_ready),
        .ch_delim           (ch_delim),
        .ch_data            (ch_data),
        .bz_input_valid     (bz_input_valid),
        .bz_input_ready     (bz_input_ready),
        .bz_input_delim     (bz_input_delim),
        .bz_input_data      (bz_input_data),
        .job_done           (job_done),
        .head_job_valid     (head_job_valid),
        .head_job_ch        (head_job_ch),
        .inflight_cnt       (inflight_cnt),
        .busy               (busy),
        .err_done_underflow (err_done_underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: is a job streaming, who owns it, rotation pointer, job owner queue.
    bit m_stream;
    int m_owner;
    int m_ptr;
    int tagq[$];
    bit m_err;

    // Channel sources: remaining beats of the current job, refill length for endless traffic.
    int src_len[N];
    int refill[N];
    bit gate_rand;

    // Observed transfers.
    int xfer_ch[$];
    int xfer_tick[$];
    int xfer_obs[N];
    logic [N-1:0] rdy_seen;
    int tick_no;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h tick=%0d", tag, got, exp, tick_no);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            ch_valid[c] = (src_len[c] > 0) && (!gate_rand || ($urandom_range(0, 3) != 0));
            ch_delim[c] = (src_len[c] == 1);
            ch_data[c*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_stream && bz_input_ready) exp_rdy[m_owner] = 1'b1;
        chk("ch_ready", ch_ready, exp_rdy);
        chk("bz_valid", bz_input_valid, m_stream ? ch_valid[m_owner] : 1'b0);
        if (m_stream) begin
            chk("bz_data", bz_input_data, ch_data[m_owner*DW +: DW]);
            chk("bz_delim", bz_input_delim, ch_delim[m_owner]);
        end
        chk("head_valid", head_job_valid, tagq.size() > 0);
        if (tagq.size() > 0) chk("head_ch", head_job_ch, tagq[0]);
        chk("inflight", inflight_cnt, tagq.size());
        chk("busy", busy, m_stream || (tagq.size() > 0));
        chk("err", err_done_underflow, m_err);
    endtask

    task automatic model_edge();
        bit xfer;
        int size_before;
        int c;
        xfer = m_stream && ch_valid[m_owner] && bz_input_ready;
        size_before = tagq.size();
        if (job_done) begin
            if (size_before > 0) void'(tagq.pop_front());
            else m_err = 1'b1;
        end
        if (!m_stream) begin
            if (cfg_enable && size_before < MAXI && ch_valid != '0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (ch_valid[c]) break;
                end
                m_owner  = c;
                m_ptr    = (c + 1) % N;
                tagq.push_back(c);
                m_stream = 1'b1;
            end
        end else if (xfer && ch_delim[m_owner]) begin
            m_stream = 1'b0;
        end
        if (xfer) begin
            src_len[m_owner]--;
            if (src_len[m_owner] == 0) src_len[m_owner] = refill[m_owner];
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        rdy_seen |= ch_ready;
        for (int c = 0; c < N; c++) begin
            if (ch_ready[c] && ch_valid[c]) begin
                xfer_ch.push_back(c);
                xfer_tick.push_back(tick_no);
                xfer_obs[c]++;
            end
        end
        model_edge();
        @(negedge clk);
        tick_no++;
        drive();
    endtask

    task automatic clear_logs();
        xfer_ch.delete();
        xfer_tick.delete();
        for (int c = 0; c < N; c++) xfer_obs[c] = 0;
        rdy_seen = '0;
        tick_no  = 0;
    endtask

    task automatic reset_all();
        rst_n          = 1'b0;
        job_done       = 1'b0;
        cfg_enable     = 1'b1;
        bz_input_ready = 1'b1;
        gate_rand      = 1'b0;
        for (int c = 0; c < N; c++) begin
            src_len[c] = 0;
            refill[c]  = 0;
        end
        drive();
        repeat (2) @(negedge clk);
        m_stream = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
        tagq.delete();
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        reset_all();

        // Reset state
        #1;
        chk("rst_ch_ready", ch_ready, 4'b0000);
        chk("rst_bz_valid", bz_input_valid, 1'b0);
        chk("rst_head_valid", head_job_valid, 1'b0);
        chk("rst_head_ch", head_job_ch, 2'd0);
        chk("rst_inflight", inflight_cnt, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_done_underflow, 1'b0);

        // Single channel, 3-beat job on ch1
        src_len[1] = 3;
        drive();
        repeat (4) tick();
        chk("t1_xfers", xfer_ch.size(), 3);
        chk("t1_first_beat_tick", xfer_tick.size() > 0 ? xfer_tick[0] : -1, 1);
        chk("t1_last_beat_tick", xfer_tick.size() > 2 ? xfer_tick[2] : -1, 3);
        #1;
        chk("t1_idle_valid", bz_input_valid, 1'b0);
        chk("t1_head_ch", head_job_ch, 2'd1);
        chk("t1_inflight", inflight_cnt, 3'd1);

        // Round-robin fairness with continuous 1-beat jobs
        reset_all();
        for (int c = 0; c < N; c++) begin
            src_len[c] = 1;
            refill[c]  = 1;
        end
        drive();
        for (int i = 0; i < 10; i++) begin
            job_done = (tagq.size() > 0);
            tick();
        end
        job_done = 1'b0;
        chk("rr_count", xfer_ch.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", i < xfer_ch.size() ? xfer_ch[i] : -1, i % N);
            chk("rr_tick", i < xfer_tick.size() ? xfer_tick[i] : -1, 2 * i + 1);
        end

        // In-flight limit
        reset_all();
        for (int c = 0; c < N; c++) begin
            src_len[c] = 1;
            refill[c]  = 1;
        end
        drive();
        repeat (12) tick();
        #1;
        chk("lim_xfers", xfer_ch.size(), 4);
        chk("lim_inflight", inflight_cnt, 3'd4);
        chk("lim_ch_ready", ch_ready, 4'b0000);
        chk("lim_head_ch", head_job_ch, 2'd0);
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        #1;
        chk("lim_after_done_inflight", inflight_cnt, 3'd3);
        chk("lim_after_done_head", head_job_ch, 2'd1);
        tick();
        #1;
        chk("lim_regrant_valid", bz_input_valid, 1'b1);
        chk("lim_regrant_ready", ch_ready, 4'b0001);

        // Simultaneous grant and job_done at inflight_cnt = 2
        reset_all();
        src_len[0] = 1;
        src_len[1] = 1;
        drive();
        repeat (4) tick();
        #1;
        chk("sim_pre_inflight", inflight_cnt, 3'd2);
        src_len[2] = 1;
        job_done   = 1'b1;
        drive();
        tick();
        job_done = 1'b0;
        #1;
        chk("sim_inflight", inflight_cnt, 3'd2);
        chk("sim_head", head_job_ch, 2'd1);
        repeat (2) tick();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        #1;
        chk("sim_head_next", head_job_ch, 2'd2);
        chk("sim_inflight_next", inflight_cnt, 3'd1);

        // Backpressure: ready toggles during a 4-beat job on ch3
        reset_all();
        src_len[3] = 4;
        drive();
        tick();
        src_len[0] = 2;
        drive();
        for (int k = 1; k < 8; k++) begin
            bz_input_ready = (k % 2 == 1);
            tick();
        end
        chk("bp_xfers_ch3", xfer_obs[3], 4);
        chk("bp_other_ready", rdy_seen & 4'b0111, 4'b0000);
        chk("bp_last_beat_tick", xfer_tick.size() > 3 ? xfer_tick[3] : -1, 7);

        // Underflow error and cfg_enable dropped mid-job
        reset_all();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        #1;
        chk("uf_err", err_done_underflow, 1'b1);
        chk("uf_inflight", inflight_cnt, 3'd0);
        src_len[2] = 3;
        drive();
        repeat (2) tick();
        cfg_enable = 1'b0;
        src_len[1] = 2;
        drive();
        repeat (6) tick();
        chk("dis_xfers_ch2", xfer_obs[2], 3);
        chk("dis_xfers_ch1", xfer_obs[1], 0);
        #1;
        chk("dis_inflight", inflight_cnt, 3'd1);
        chk("dis_bz_valid", bz_input_valid, 1'b0);
        chk("dis_err_sticky", err_done_underflow, 1'b1);

        // Randomized traffic against the reference model, with one mid-run reset
        reset_all();
        gate_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                reset_all();
                gate_rand = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                if (src_len[c] == 0 && $urandom_range(0, 3) == 0) src_len[c] = $urandom_range(1, 4);
            end
            bz_input_ready = ($urandom_range(0, 3) != 0);
            job_done       = ($urandom_range(0, 4) == 0);
            cfg_enable     = ($urandom_range(0, 15) != 0);
            drive();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beezip_job_scheduler.md
# beezip_job_scheduler

Job-level scheduler that shares one `beezip` compressor instance among `NUM_CH` independent input streams. It grants the compressor to one channel for a whole job, which is the beats up to and including the `input_delim` beat. Grants rotate round-robin. It records which channel owns each in-flight job so downstream logic can steer `output_seq_quad` traffic back to the correct requester. It sits directly in front of `beezip`'s input port and limits the number of jobs in flight inside the compressor.

## Interface
- `NUM_CH`, default 4: number of requesting channels, minimum 2.
- `CH_W`, default 2: channel index width, equal to clog2(`NUM_CH`).
- `MAX_INFLIGHT`, default 4: maximum number of jobs granted but not yet retired; a power of 2.
- `DATA_W`, default `` `HASH_ISSUE_WIDTH*8 ``: beat width.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cfg_enable`, in, 1: allows new grants. Clearing it lets the current job finish.
- `ch_valid`, in, `NUM_CH`: per-channel beat valid.
- `ch_ready`, out, `NUM_CH`: per-channel beat ready.
- `ch_delim`, in, `NUM_CH`: per-channel last-beat-of-job flag.
- `ch_data`, in, `NUM_CH*DATA_W`: per-channel beat data. Channel i occupies bits [i*DATA_W +: DATA_W].
- `bz_input_valid`, out, 1: beat valid to `beezip`.
- `bz_input_ready`, in, 1: beat ready from `beezip`.
- `bz_input_delim`, out, 1: delim to `beezip`.
- `bz_input_data`, out, `DATA_W`: data to `beezip`.
- `job_done`, in, 1: one-cycle pulse from the downstream sequence writer when the oldest job's last sequence has been retired.
- `head_job_valid`, out, 1: at least one job is in flight.
- `head_job_ch`, out, `CH_W`: owning channel of the oldest in-flight job.
- `inflight_cnt`, out, clog2(`MAX_INFLIGHT`)+1: number of jobs currently in flight.
- `busy`, out, 1: FSM is not in IDLE, or `inflight_cnt` is not 0.
- `err_done_underflow`, out, 1: sticky flag. Set when `job_done` arrives while no job is in flight.

## Operation
- FSM states are IDLE and STREAM.
- **IDLE:**
  - A grant is possible when `cfg_enable`=1, `inflight_cnt` < `MAX_INFLIGHT`, and at least one `ch_valid` is set.
  - When a grant is possible, pick the first valid channel searching upward from `rr_ptr`, wrapping modulo `NUM_CH`.
  - Register that channel in `grant_ch`, push `grant_ch` into the tag FIFO, increment `inflight_cnt`, and move to STREAM.
  - `rr_ptr` becomes (`grant_ch`+1) mod `NUM_CH`.
- **STREAM:**
  - Combinational passthrough for the granted channel: `bz_input_valid`=`ch_valid[grant_ch]`, `bz_input_data`/`bz_input_delim` come from `grant_ch`, and `ch_ready[grant_ch]`=`bz_input_ready`.
  - All other `ch_ready` are 0.
  - A beat with valid, ready and delim all high returns the FSM to IDLE.
- Outside STREAM, `bz_input_valid`=0 and all `ch_ready`=0. `bz_input_data`/`bz_input_delim` are don't-care but must be driven.
- **Tag FIFO:**
  - Depth `MAX_INFLIGHT`, width `CH_W`.
  - `head_job_ch` is the FIFO head and `head_job_valid` is FIFO not-empty.
  - `job_done` pops the FIFO and decrements `inflight_cnt`.
- **Simultaneous grant and `job_done` in the same cycle:** push and pop both happen, and `inflight_cnt` is unchanged. This case must work even when the FIFO holds `MAX_INFLIGHT` entries; the grant condition is evaluated on the registered count, so no grant is issued when the count is full.
- **`job_done` with `inflight_cnt`=0:** ignored (no pop, no decrement) and `err_done_underflow` is set.
- **`cfg_enable` dropped mid-STREAM:** the current job runs to its delim beat, then the FSM stays in IDLE.
- **Reset mid-job:** all state is cleared. The integrator resets `beezip` on the same `rst_n`, so no partial job survives.

## Timing
- Reset values: FSM=IDLE, `rr_ptr`=0, `grant_ch`=0, `inflight_cnt`=0, FIFO empty. Outputs: `ch_ready`=0, `bz_input_valid`=0, `head_job_valid`=0, `head_job_ch`=0, `busy`=0, `err_done_underflow`=0.
- Grant is registered: request seen in IDLE at cycle t means the first beat can transfer at t+1.
- Datapath latency in STREAM is 0 cycles (no register between channel and `beezip`).
- Each job boundary costs exactly one IDLE bubble cycle: delim accepted at t, next grant at t+1, next beat at t+2.
- `head_job_valid`/`inflight_cnt` update in the cycle after a push or pop.
- `err_done_underflow` is set in the cycle after the offending pulse and clears only on reset.

## Structure
- `SCHED_NUM_CH` and `SCHED_MAX_INFLIGHT` defaults belong in `parameters.vh`, alongside `HASH_ISSUE_WIDTH`.
- The tag FIFO is an instance of the existing `fifo` module (`W`=`CH_W`, `DEPTH`=`MAX_INFLIGHT`); its `input_ready` must always be 1 whenever a grant is issued.
- The round-robin pick is an inline function; no further sub-modules.

## Test plan
- **Single channel, 3-beat job:** ch1 presents 3 beats, delim on beat 3, `bz_input_ready`=1 → beats at cycles 2,3,4, IDLE at cycle 5, `head_job_ch`=1, `inflight_cnt`=1.
- **Round-robin fairness:** all 4 channels hold 1-beat jobs continuously → grant order 0,1,2,3,0; one bubble between jobs.
- **In-flight limit:** `MAX_INFLIGHT`=4, no `job_done` → after 4 jobs no grant and `ch_ready`=0. A `job_done` pulse gives a grant on the next cycle, with `head_job_ch` advancing to the second job's channel.
- **Simultaneous grant and `job_done` at `inflight_cnt`=2** → count stays 2, FIFO order preserved.
- **Backpressure:** `bz_input_ready` toggles 1010 during a 4-beat job → exactly 4 transfers, `ch_ready` mirrors `bz_input_ready`, and no other channel's `ch_ready` rises.
- **Error and disable:** `job_done` on an empty FIFO sets `err_done_underflow`=1 with `inflight_cnt` staying 0. `cfg_enable` dropped mid-job lets the delim complete, then no new grant.
